// File: rtl/gfx_flash_dma_pkg.sv
// rtl/gfx_flash_dma_pkg.sv - shared register map, control/status bits and FSM encoding for gfx_flash_dma
package gfx_flash_dma_pkg;

    // CPU register offsets
    localparam logic [3:0] REG_DEST   = 4'h0;
    localparam logic [3:0] REG_COUNT  = 4'h1;
    localparam logic [3:0] REG_CTRL   = 4'h2;
    localparam logic [3:0] REG_STATUS = 4'h3;
    localparam logic [3:0] REG_REMAIN = 4'h4;

    // CTRL write bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_CLR_DONE = 2;

    // STATUS read bits
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ABORTED = 2;

    // Transfer FSM: wait for low byte, wait for high byte, write word
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

endpackage

// File: rtl/gfx_flash_dma.sv
// rtl/gfx_flash_dma.sv - CPU-programmed DMA packing flash bytes into 16-bit graphics memory writes
module gfx_flash_dma
    import gfx_flash_dma_pkg::*;
#(
    parameter int BITS         = 16,
    parameter int ADDRESS_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic [ADDRESS_BITS-1:0] ADDRESS,
    input  logic [BITS-1:0]         DATA_IN,
    output logic [BITS-1:0]         DATA_OUT,
    input  logic                    WR,
    input  logic [7:0]              flash_byte,
    input  logic                    flash_byte_valid,
    output logic                    flash_byte_ready,
    output logic [BITS-1:0]         flash_dma_address,
    output logic [BITS-1:0]         flash_dma_data,
    output logic                    flash_dma_wvalid,
    input  logic                    flash_dma_wready,
    output logic                    busy,
    output logic                    done_irq
);

    state_t                  state;
    state_t                  state_next;

    logic [BITS-1:0]         dest;
    logic [BITS-1:0]         count;
    logic [BITS-1:0]         remain;
    logic [BITS-1:0]         wptr;
    logic [BITS-1:0]         word;
    logic                    done;
    logic                    aborted;
    logic [ADDRESS_BITS-1:0] addr_q;

    logic                    wr_dest;
    logic                    wr_count;
    logic                    wr_ctrl;
    logic                    start_cmd;
    logic                    abort_cmd;
    logic                    clr_cmd;
    logic                    byte_fire;
    logic                    write_fire;
    logic                    launch;
    logic                    zero_done;
    logic                    finish;
    logic                    abort_now;

    // CPU write decode; ABORT dominates START within the same CTRL write
    always_comb begin
        wr_dest    = WR && (ADDRESS == ADDRESS_BITS'(REG_DEST));
        wr_count   = WR && (ADDRESS == ADDRESS_BITS'(REG_COUNT));
        wr_ctrl    = WR && (ADDRESS == ADDRESS_BITS'(REG_CTRL));
        start_cmd  = wr_ctrl && DATA_IN[CTRL_START] && !DATA_IN[CTRL_ABORT];
        abort_cmd  = wr_ctrl && DATA_IN[CTRL_ABORT];
        clr_cmd    = wr_ctrl && DATA_IN[CTRL_CLR_DONE];
        byte_fire  = flash_byte_ready && flash_byte_valid;
        write_fire = flash_dma_wvalid && flash_dma_wready;
        launch     = (state == ST_IDLE) && start_cmd && (count != '0);
        zero_done  = (state == ST_IDLE) && start_cmd && (count == '0);
        finish     = (state == ST_WR) && write_fire && (remain == BITS'(1)) && !abort_cmd;
        abort_now  = (state != ST_IDLE) && abort_cmd;
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; abort returns to idle from any busy state
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch) state_next = ST_LO;
            ST_LO: begin
                if (abort_cmd)      state_next = ST_IDLE;
                else if (byte_fire) state_next = ST_HI;
            end
            ST_HI: begin
                if (abort_cmd)      state_next = ST_IDLE;
                else if (byte_fire) state_next = ST_WR;
            end
            ST_WR: begin
                if (abort_cmd)       state_next = ST_IDLE;
                else if (write_fire) state_next = (remain == BITS'(1)) ? ST_IDLE : ST_LO;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: byte port open only while collecting, write port only in WR
    always_comb begin
        flash_byte_ready = (state == ST_LO) || (state == ST_HI);
        flash_dma_wvalid = (state == ST_WR);
        busy             = (state != ST_IDLE);
    end

    // CPU-visible configuration registers, writable at any time
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            dest  <= '0;
            count <= '0;
        end else begin
            if (wr_dest)  dest  <= DATA_IN;
            if (wr_count) count <= DATA_IN;
        end
    end

    // Transfer datapath: pointer, remaining count and little-endian byte packer
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wptr   <= '0;
            remain <= '0;
            word   <= '0;
        end else begin
            if (launch) begin
                wptr   <= dest;
                remain <= count;
            end else if (write_fire) begin
                wptr   <= wptr + 1'b1;
                remain <= remain - 1'b1;
            end
            if (byte_fire && (state == ST_LO)) word[7:0]  <= flash_byte;
            if (byte_fire && (state == ST_HI)) word[15:8] <= flash_byte;
        end
    end

    // Sticky status flags and completion pulse; completion beats CLR_DONE
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            done     <= 1'b0;
            aborted  <= 1'b0;
            done_irq <= 1'b0;
        end else begin
            done_irq <= finish || zero_done;
            if (launch)                   done <= 1'b0;
            else if (finish || zero_done) done <= 1'b1;
            else if (clr_cmd)             done <= 1'b0;
            if (launch)         aborted <= 1'b0;
            else if (abort_now) aborted <= 1'b1;
            else if (clr_cmd)   aborted <= 1'b0;
        end
    end

    // Read address is registered, giving one cycle of read latency
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            addr_q <= '0;
        end else begin
            addr_q <= ADDRESS;
        end
    end

    // Read data mux from the registered address
    always_comb begin
        DATA_OUT = '0;
        case (addr_q)
            ADDRESS_BITS'(REG_DEST):   DATA_OUT = dest;
            ADDRESS_BITS'(REG_COUNT):  DATA_OUT = count;
            ADDRESS_BITS'(REG_STATUS): begin
                DATA_OUT[STAT_BUSY]    = busy;
                DATA_OUT[STAT_DONE]    = done;
                DATA_OUT[STAT_ABORTED] = aborted;
            end
            ADDRESS_BITS'(REG_REMAIN): DATA_OUT = remain;
            default:                   DATA_OUT = '0;
        endcase
    end

    assign flash_dma_address = wptr;
    assign flash_dma_data    = word;

endmodule
